// File: rtl/sram_bus_if.sv
// sram_bus_if: pipeline-side request/response and external SRAM pins of sram_bus_ctrl
interface sram_bus_if #(parameter int ADDR_W = 20);
  logic              if_ce_i;
  logic [31:0]       if_addr_i;
  logic [31:0]       if_data_o;
  logic              mem_ce_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [31:0]       mem_data_i;
  logic [31:0]       mem_data_o;
  logic              stallreq_o;
  logic              flush_i;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_dq_i;
  logic [31:0]       sram_dq_o;
  logic              sram_dq_oe_o;
  logic              sram_ce_n_o;
  logic              sram_oe_n_o;
  logic              sram_we_n_o;
  logic [3:0]        sram_be_n_o;
  modport slave (
    input  if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, flush_i, sram_dq_i,
    output if_data_o, mem_data_o, stallreq_o, sram_addr_o, sram_dq_o, sram_dq_oe_o,
           sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );
  modport master (
    output if_ce_i, if_addr_i, mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i, flush_i, sram_dq_i,
    input  if_data_o, mem_data_o, stallreq_o, sram_addr_o, sram_dq_o, sram_dq_oe_o,
           sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// sram_bus_ctrl: serialises data and fetch accesses onto one SRAM; SRAM_BUS_IBUF_EN adds a one-entry fetch buffer
module sram_bus_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 1,
  parameter int WR_SETUP = 1
) (
  input logic      clk,
  input logic      rst,
  sram_bus_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_D, WR_S, WR_P, WR_H, RD_I, DONE} state_t;
  state_t state, nx, after_d;
  logic [2:0] cnt;
  logic fl, hit, fetch, last, rd_nx, wr_nx;
  logic [ADDR_W-1:0] if_word, mem_word;
  logic unused;
  assign unused = ^{bus.if_addr_i[31:ADDR_W+2], bus.if_addr_i[1:0], bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[1:0]};
  assign if_word  = bus.if_addr_i[ADDR_W+1:2];
  assign mem_word = bus.mem_addr_i[ADDR_W+1:2];
  assign last     = cnt == 3'(RD_WAIT);
`ifdef SRAM_BUS_IBUF_EN
  logic [ADDR_W-1:0] tag;
  logic [31:0] ibuf;
  logic valid;
  assign hit = bus.if_ce_i & valid & (tag == if_word);
`else
  assign hit = 1'b0;
`endif
  assign fetch   = bus.if_ce_i & !hit;
  assign after_d = fetch ? RD_I : DONE;
  assign rd_nx   = nx == RD_D || nx == RD_I;
  assign wr_nx   = nx == WR_S || nx == WR_P || nx == WR_H;
  assign bus.stallreq_o = !bus.flush_i & ((state == IDLE & (bus.if_ce_i | bus.mem_ce_i)) | (state != IDLE & state != DONE));
  // A write that has reached WR_P always completes its hold phase, even under flush
  always_comb begin
    nx = IDLE;
    case (state)
      IDLE:    nx = bus.flush_i ? IDLE : bus.mem_ce_i ? (bus.mem_we_i ? WR_S : RD_D) : fetch ? RD_I : bus.if_ce_i ? DONE : IDLE;
      RD_D:    nx = bus.flush_i ? IDLE : last ? after_d : RD_D;
      WR_S:    nx = bus.flush_i ? IDLE : (cnt == 3'(WR_SETUP - 1)) ? WR_P : WR_S;
      WR_P:    nx = WR_H;
      WR_H:    nx = (fl | bus.flush_i) ? IDLE : after_d;
      RD_I:    nx = bus.flush_i ? IDLE : last ? DONE : RD_I;
      default: nx = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      fl               <= 1'b0;
      bus.sram_ce_n_o  <= 1'b1;
      bus.sram_oe_n_o  <= 1'b1;
      bus.sram_we_n_o  <= 1'b1;
      bus.sram_be_n_o  <= 4'hF;
      bus.sram_dq_oe_o <= 1'b0;
      bus.sram_addr_o  <= '0;
      bus.sram_dq_o    <= '0;
      bus.if_data_o    <= '0;
      bus.mem_data_o   <= '0;
    end else begin
      state            <= nx;
      cnt              <= (nx == state && state != IDLE) ? cnt + 3'd1 : 3'd0;
      fl               <= state == WR_P && bus.flush_i;
      bus.sram_ce_n_o  <= !(rd_nx | wr_nx);
      bus.sram_oe_n_o  <= !rd_nx;
      bus.sram_we_n_o  <= nx != WR_P;
      bus.sram_be_n_o  <= rd_nx ? 4'h0 : wr_nx ? ~bus.mem_sel_i : 4'hF;
      bus.sram_dq_oe_o <= wr_nx;
      bus.sram_addr_o  <= nx == RD_I ? if_word : (nx == RD_D || wr_nx) ? mem_word : bus.sram_addr_o;
      bus.sram_dq_o    <= wr_nx ? bus.mem_data_i : bus.sram_dq_o;
      if (state == RD_D && last && !bus.flush_i) bus.mem_data_o <= bus.sram_dq_i;
      if (state == RD_I && last && !bus.flush_i) bus.if_data_o <= bus.sram_dq_i;
`ifdef SRAM_BUS_IBUF_EN
      else if (hit && nx == DONE) bus.if_data_o <= ibuf;
`endif
    end
  end
`ifdef SRAM_BUS_IBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      ibuf  <= '0;
    end else if (state == RD_I && last && !bus.flush_i) begin
      valid <= 1'b1;
      tag   <= bus.sram_addr_o;
      ibuf  <= bus.sram_dq_i;
    end else if (state == WR_P && bus.sram_addr_o == tag) valid <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_sram_bus_ctrl.sv
// tb_sram_bus_ctrl: directed self-checking bench for sram_bus_ctrl with a small SRAM model
module tb_sram_bus_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] mem_m [0:255];
  always #5 clk = ~clk;
  sram_bus_if #(.ADDR_W(20)) bus();
  sram_bus_ctrl #(.ADDR_W(20), .RD_WAIT(1), .WR_SETUP(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.sram_dq_i = mem_m[bus.sram_addr_o[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_m[i] <= 32'h0;
      mem_m[8'h01] <= 32'h24080001;
      mem_m[8'h02] <= 32'h00000013;
      mem_m[8'h80] <= 32'hDEADBEEF;
      mem_m[8'h81] <= 32'h55AA55AA;
    end else if (!bus.sram_we_n_o) begin
      for (int i = 0; i < 4; i++)
        if (!bus.sram_be_n_o[i]) mem_m[bus.sram_addr_o[7:0]][i*8 +: 8] <= bus.sram_dq_o[i*8 +: 8];
    end
  end

  task automatic run_step(output int n, output int we_lo, output int we_at, output logic [19:0] a1,
                          output logic [19:0] aw, output logic [3:0] be_w, output logic oe_w, output logic [31:0] dq_w);
    n = 0; we_lo = 0; we_at = -1; a1 = '0; aw = '0; be_w = '0; oe_w = 1'b0; dq_w = '0;
    #1;
    while (bus.stallreq_o && n < 40) begin
      if (n == 1) a1 = bus.sram_addr_o;
      if (!bus.sram_we_n_o) begin
        we_lo++;
        if (we_at < 0) begin
          we_at = n; aw = bus.sram_addr_o; be_w = bus.sram_be_n_o; oe_w = bus.sram_dq_oe_o; dq_w = bus.sram_dq_o;
        end
      end
      n++;
      @(negedge clk); #1;
    end
    bus.if_ce_i = 1'b0;
    bus.mem_ce_i = 1'b0;
    bus.mem_we_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (bus.sram_ce_n_o !== 1'b1) begin failures++; $display("FAIL rst_ce_n got=%b exp=1", bus.sram_ce_n_o); end
    checks++; if (bus.sram_oe_n_o !== 1'b1) begin failures++; $display("FAIL rst_oe_n got=%b exp=1", bus.sram_oe_n_o); end
    checks++; if (bus.sram_we_n_o !== 1'b1) begin failures++; $display("FAIL rst_we_n got=%b exp=1", bus.sram_we_n_o); end
    checks++; if (bus.sram_be_n_o !== 4'hF) begin failures++; $display("FAIL rst_be_n got=%h exp=F", bus.sram_be_n_o); end
    checks++; if (bus.sram_dq_oe_o !== 1'b0) begin failures++; $display("FAIL rst_dq_oe got=%b exp=0", bus.sram_dq_oe_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stallreq_o); end
    checks++; if (bus.if_data_o !== 32'h0) begin failures++; $display("FAIL rst_if_data got=%h exp=0", bus.if_data_o); end
    checks++; if (bus.mem_data_o !== 32'h0) begin failures++; $display("FAIL rst_mem_data got=%h exp=0", bus.mem_data_o); end
    checks++; if (bus.sram_addr_o !== 20'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.sram_addr_o); end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    int n, wl, wa; logic [19:0] a1, aw; logic [3:0] be; logic oe; logic [31:0] dq;
    @(negedge clk);
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000004;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== 3) begin failures++; $display("FAIL fetch_stall got=%0d exp=3", n); end
    checks++; if (a1 !== 20'h00001) begin failures++; $display("FAIL fetch_addr got=%h exp=00001", a1); end
    checks++; if (bus.if_data_o !== 32'h24080001) begin failures++; $display("FAIL fetch_data got=%h exp=24080001", bus.if_data_o); end
    checks++; if (bus.sram_ce_n_o !== 1'b1) begin failures++; $display("FAIL fetch_idle_ce_n got=%b exp=1", bus.sram_ce_n_o); end
  endtask

  task automatic test_store_fetch;
    int n, wl, wa; logic [19:0] a1, aw; logic [3:0] be; logic oe; logic [31:0] dq;
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h80000101; bus.mem_sel_i = 4'b0010;
    bus.mem_data_i = 32'h0000AB00; bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000008;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== 6) begin failures++; $display("FAIL store_stall got=%0d exp=6", n); end
    checks++; if (wl !== 1) begin failures++; $display("FAIL store_we_len got=%0d exp=1", wl); end
    checks++; if (wa !== 2) begin failures++; $display("FAIL store_we_pos got=%0d exp=2", wa); end
    checks++; if (be !== 4'b1101) begin failures++; $display("FAIL store_be_n got=%b exp=1101", be); end
    checks++; if (oe !== 1'b1) begin failures++; $display("FAIL store_dq_oe got=%b exp=1", oe); end
    checks++; if (dq !== 32'h0000AB00) begin failures++; $display("FAIL store_dq got=%h exp=0000ab00", dq); end
    checks++; if (aw !== 20'h00040) begin failures++; $display("FAIL store_addr got=%h exp=00040", aw); end
    checks++; if (bus.if_data_o !== 32'h00000013) begin failures++; $display("FAIL store_fetch_data got=%h exp=00000013", bus.if_data_o); end
  endtask

  task automatic test_load_fetch;
    int n, wl, wa; logic [19:0] a1, aw; logic [3:0] be; logic oe; logic [31:0] dq;
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h80000200; bus.mem_sel_i = 4'hF;
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000008;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== 5) begin failures++; $display("FAIL load_stall got=%0d exp=5", n); end
    checks++; if (a1 !== 20'h00080) begin failures++; $display("FAIL load_addr got=%h exp=00080", a1); end
    checks++; if (wl !== 0) begin failures++; $display("FAIL load_we_len got=%0d exp=0", wl); end
    checks++; if (bus.mem_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", bus.mem_data_o); end
    checks++; if (bus.if_data_o !== 32'h00000013) begin failures++; $display("FAIL load_fetch_data got=%h exp=00000013", bus.if_data_o); end
  endtask

  task automatic test_flush_rd;
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h80000204;
    #1;
    checks++; if (bus.stallreq_o !== 1'b1) begin failures++; $display("FAIL flrd_idle_stall got=%b exp=1", bus.stallreq_o); end
    @(negedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL flrd_stall got=%b exp=0", bus.stallreq_o); end
    @(negedge clk);
    bus.flush_i = 1'b0; bus.mem_ce_i = 1'b0;
    #1;
    checks++; if (bus.sram_ce_n_o !== 1'b1) begin failures++; $display("FAIL flrd_ce_n got=%b exp=1", bus.sram_ce_n_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL flrd_idle got=%b exp=0", bus.stallreq_o); end
    checks++; if (bus.mem_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL flrd_data got=%h exp=deadbeef", bus.mem_data_o); end
  endtask

  task automatic test_flush_wr;
    int n, wl, wa, exp_hit; logic [19:0] a1, aw; logic [3:0] be; logic oe; logic [31:0] dq;
`ifdef SRAM_BUS_IBUF_EN
    exp_hit = 1;
`else
    exp_hit = 3;
`endif
    @(negedge clk);
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000004;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== 3) begin failures++; $display("FAIL ibuf_miss_stall got=%0d exp=3", n); end
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000004;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== exp_hit) begin failures++; $display("FAIL ibuf_repeat_stall got=%0d exp=%0d", n, exp_hit); end
    checks++; if (bus.if_data_o !== 32'h24080001) begin failures++; $display("FAIL ibuf_repeat_data got=%h exp=24080001", bus.if_data_o); end
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h80000004; bus.mem_sel_i = 4'hF;
    bus.mem_data_i = 32'h11223344;
    @(negedge clk);
    #1;
    checks++; if (bus.sram_dq_oe_o !== 1'b1 || bus.sram_we_n_o !== 1'b1) begin failures++; $display("FAIL flwr_setup oe=%b we_n=%b exp oe=1 we_n=1", bus.sram_dq_oe_o, bus.sram_we_n_o); end
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.sram_we_n_o !== 1'b0) begin failures++; $display("FAIL flwr_pulse got=%b exp=0", bus.sram_we_n_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL flwr_stall got=%b exp=0", bus.stallreq_o); end
    @(negedge clk);
    bus.flush_i = 1'b0; bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
    #1;
    checks++; if (bus.sram_we_n_o !== 1'b1 || bus.sram_ce_n_o !== 1'b0 || bus.sram_dq_oe_o !== 1'b1) begin failures++; $display("FAIL flwr_hold we_n=%b ce_n=%b oe=%b exp 1 0 1", bus.sram_we_n_o, bus.sram_ce_n_o, bus.sram_dq_oe_o); end
    checks++; if (bus.stallreq_o !== 1'b1) begin failures++; $display("FAIL flwr_hold_stall got=%b exp=1", bus.stallreq_o); end
    @(negedge clk);
    #1;
    checks++; if (bus.sram_ce_n_o !== 1'b1 || bus.sram_dq_oe_o !== 1'b0) begin failures++; $display("FAIL flwr_idle ce_n=%b oe=%b exp 1 0", bus.sram_ce_n_o, bus.sram_dq_oe_o); end
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h80000004;
    run_step(n, wl, wa, a1, aw, be, oe, dq);
    checks++; if (n !== 3) begin failures++; $display("FAIL inval_stall got=%0d exp=3", n); end
    checks++; if (bus.if_data_o !== 32'h11223344) begin failures++; $display("FAIL inval_data got=%h exp=11223344", bus.if_data_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.mem_ce_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h80000008; bus.mem_sel_i = 4'hF;
    bus.mem_data_i = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.sram_we_n_o !== 1'b0) begin failures++; $display("FAIL rmid_pulse got=%b exp=0", bus.sram_we_n_o); end
    rst = 1'b1;
    @(negedge clk);
    bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
    #1;
    checks++; if (bus.sram_we_n_o !== 1'b1 || bus.sram_ce_n_o !== 1'b1 || bus.sram_dq_oe_o !== 1'b0) begin failures++; $display("FAIL rmid_strobes we_n=%b ce_n=%b oe=%b exp 1 1 0", bus.sram_we_n_o, bus.sram_ce_n_o, bus.sram_dq_oe_o); end
    checks++; if (bus.sram_be_n_o !== 4'hF) begin failures++; $display("FAIL rmid_be_n got=%h exp=F", bus.sram_be_n_o); end
    checks++; if (bus.if_data_o !== 32'h0 || bus.mem_data_o !== 32'h0) begin failures++; $display("FAIL rmid_data if=%h mem=%h exp 0 0", bus.if_data_o, bus.mem_data_o); end
    checks++; if (bus.stallreq_o !== 1'b0) begin failures++; $display("FAIL rmid_stall got=%b exp=0", bus.stallreq_o); end
    rst = 1'b0;
  endtask

  initial begin
    bus.if_ce_i = 1'b0; bus.if_addr_i = '0; bus.mem_ce_i = 1'b0; bus.mem_we_i = 1'b0;
    bus.mem_addr_i = '0; bus.mem_sel_i = '0; bus.mem_data_i = '0; bus.flush_i = 1'b0;
    test_reset;
    test_fetch;
    test_store_fetch;
    test_load_fetch;
    test_flush_rd;
    test_flush_wr;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
